lbp_host_mem: RTL and testbench

//   Host-side responder for the LBP engine's pixel interfaces.
//   - Preloads a 128x128 8-bit gray image from a streaming load port.
//   - Serves the engine's gray_req/gray_addr read requests.
//   - Captures the engine's lbp_valid result writes.
//   - On the engine's finish, streams the 128x128 result image out in raster order.

---
 rtl/lbp_pkg.sv | 30 +++
 rtl/lbp_pix_ram.sv | 24 ++
 rtl/lbp_host_mem.sv | 180 ++++++++++++++++++
 tb/tb_lbp_host_mem.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, pixel/address types, host FSM state encoding and the border test
// for the LBP host memory block.
package lbp_pkg;

  localparam int IMG_W        = 128;
  localparam int AW           = 14;
  localparam int DW           = 8;
  localparam int IMG_PIX      = IMG_W * IMG_W;
  localparam int INTERIOR_PIX = (IMG_W - 2) * (IMG_W - 2);

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] pix_t;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Row is the upper half of the address, column the lower half.
  function automatic logic is_border(input addr_t a);
    logic [AW/2-1:0] row;
    logic [AW/2-1:0] col;
    row = a[AW-1:AW/2];
    col = a[AW/2-1:0];
    return (row == '0) || (row == '1) || (col == '0) || (col == '1);
  endfunction

endpackage

// File: rtl/lbp_pix_ram.sv
// Pixel store: one synchronous write port and one asynchronous (zero-latency) read port.
module lbp_pix_ram #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side responder for the LBP engine: loads the gray image, serves reads, captures
// results and streams them back out. Optional coverage checking under LBP_COVER_CHECK_EN.
//
// state | meaning
// LOAD  | accepting gray pixels in raster order from the load port
// SERVE | engine reads gray pixels and writes results
// DRAIN | result image streamed out in raster order
// DONE  | readback complete, all handshakes idle until reset
module lbp_host_mem
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic          gray_ready,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic [AW:0]   wr_count,
  output logic          err_border,
  output logic          err_dup,
  output logic          err_missing,
  output logic          done
);

  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SERVE = ST_SERVE;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  localparam logic [AW:0] CNT_SAT      = (AW+1)'(IMG_PIX);
  localparam logic [AW:0] CNT_INTERIOR = (AW+1)'(INTERIOR_PIX);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  addr_t         r_ld_ptr;
  addr_t         r_rd_ptr;
  logic [AW:0]   r_wr_count;
  logic [AW:0]   w_wr_count_nxt;
  logic          r_err_border;

  logic          w_ld_fire;
  logic          w_ld_last;
  logic          w_lbp_hit;
  logic          w_lbp_border;
  logic          w_res_we;
  logic          w_rd_fire;
  logic          w_rd_at_last;
  logic          w_serve_exit;
  pix_t          w_gray_rdata;
  pix_t          w_res_rdata;

  // gray_req is informational only: reads are combinational on gray_addr.
  logic          w_unused_req;
  assign w_unused_req = gray_req;

  assign w_ld_fire    = (r_state == S_LOAD) && ld_valid;
  assign w_ld_last    = w_ld_fire && (r_ld_ptr == '1);
  assign w_lbp_hit    = (r_state == S_SERVE) && lbp_valid;
  assign w_lbp_border = is_border(lbp_addr);
  assign w_res_we     = w_lbp_hit && !w_lbp_border;
  assign w_serve_exit = (r_state == S_SERVE) && finish;
  assign w_rd_fire    = (r_state == S_DRAIN) && rd_ready;
  assign w_rd_at_last = (r_rd_ptr == '1);

  assign w_wr_count_nxt = (w_res_we && (r_wr_count != CNT_SAT)) ? r_wr_count + 1'b1
                                                                 : r_wr_count;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOAD:  if (w_ld_last)                   w_state_nxt = S_SERVE;
      S_SERVE: if (finish)                      w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_rd_fire && w_rd_at_last)   w_state_nxt = S_DONE;
      default:                                  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_ld_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_wr_count   <= '0;
      r_err_border <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_count <= w_wr_count_nxt;
      if (w_ld_fire) begin
        r_ld_ptr <= r_ld_ptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_lbp_hit && w_lbp_border) begin
        r_err_border <= 1'b1;
      end
    end
  end

  lbp_pix_ram #(.AW(AW), .DW(DW)) u_gray_mem (
    .clk     (clk),
    .i_we    (w_ld_fire),
    .i_waddr (r_ld_ptr),
    .i_wdata (ld_data),
    .i_raddr (gray_addr),
    .o_rdata (w_gray_rdata)
  );

  lbp_pix_ram #(.AW(AW), .DW(DW)) u_res_mem (
    .clk     (clk),
    .i_we    (w_res_we),
    .i_waddr (lbp_addr),
    .i_wdata (lbp_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_res_rdata)
  );

  assign ld_ready   = (r_state == S_LOAD);
  assign gray_ready = (r_state == S_SERVE);
  assign gray_data  = (r_state == S_SERVE) ? w_gray_rdata : '0;
  assign rd_valid   = (r_state == S_DRAIN);
  // Border results are never written, so their memory cells hold stale data.
  assign rd_data    = ((r_state == S_DRAIN) && !is_border(r_rd_ptr)) ? w_res_rdata : '0;
  assign rd_last    = (r_state == S_DRAIN) && w_rd_at_last;
  assign wr_count   = r_wr_count;
  assign err_border = r_err_border;
  assign done       = (r_state == S_DONE);

`ifdef LBP_COVER_CHECK_EN
  logic [IMG_PIX-1:0] r_written;
  logic               r_err_dup;
  logic               r_err_missing;

  // Bitmap is scrubbed one bit per load beat instead of by reset.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_written[r_ld_ptr] <= 1'b0;
    end else if (w_res_we) begin
      r_written[lbp_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_dup     <= 1'b0;
      r_err_missing <= 1'b0;
    end else begin
      if (w_res_we && r_written[lbp_addr]) begin
        r_err_dup <= 1'b1;
      end
      // Uses the post-write count so a write coinciding with finish is included.
      if (w_serve_exit) begin
        r_err_missing <= (w_wr_count_nxt != CNT_INTERIOR);
      end
    end
  end

  assign err_dup     = r_err_dup;
  assign err_missing = r_err_missing;
`else
  logic w_unused_exit;
  logic w_unused_cnt;
  assign w_unused_exit = w_serve_exit;
  assign w_unused_cnt  = |CNT_INTERIOR;
  assign err_dup       = 1'b0;
  assign err_missing   = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: load, serve table, full result drain, mid-drain reset.
module tb_lbp_host_mem;
  import lbp_pkg::*;

`ifdef LBP_COVER_CHECK_EN
  localparam bit COVER = 1'b1;
`else
  localparam bit COVER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          gray_ready;
  logic [DW-1:0] gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [DW-1:0] lbp_data;
  logic          finish;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready;
  logic [AW:0]   wr_count;
  logic          err_border;
  logic          err_dup;
  logic          err_missing;
  logic          done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lbp_host_mem dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .gray_req    (gray_req),
    .gray_addr   (gray_addr),
    .gray_ready  (gray_ready),
    .gray_data   (gray_data),
    .lbp_valid   (lbp_valid),
    .lbp_addr    (lbp_addr),
    .lbp_data    (lbp_data),
    .finish      (finish),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .rd_ready    (rd_ready),
    .wr_count    (wr_count),
    .err_border  (err_border),
    .err_dup     (err_dup),
    .err_missing (err_missing),
    .done        (done)
  );

  typedef struct {
    bit          is_wr;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_gray;
    logic [14:0] exp_cnt;
    bit          exp_border;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit tb_border(input int a);
    int row;
    int col;
    row = a / 128;
    col = a % 128;
    return (row == 0) || (row == 127) || (col == 0) || (col == 127);
  endfunction

  function automatic logic [7:0] drain_exp(input int a);
    if (tb_border(a)) return 8'h00;
    if (a == 129)     return 8'h5A;
    return 8'(a);
  endfunction

  // gap_mod > 0 drops ld_valid on every gap_mod-th cycle.
  task automatic load_image(input int gap_mod, input string tag);
    int acc;
    int cyc;
    acc = 0;
    cyc = 0;
    while (acc < IMG_PIX && cyc < 20000) begin
      ld_valid = (gap_mod == 0) ? 1'b1 : ((cyc % gap_mod) != gap_mod - 1);
      ld_data  = 8'(acc);
      #1;
      if (ld_valid && ld_ready) begin
        if (acc == IMG_PIX - 1) chk({tag, "_gray_ready_before_last"}, gray_ready, 0);
        acc++;
      end
      cyc++;
      tick();
    end
    #1;
    chk({tag, "_accepts"}, acc, IMG_PIX);
    chk({tag, "_gray_ready_after_last"}, gray_ready, 1);
    chk({tag, "_ld_ready_after_last"}, ld_ready, 0);
    ld_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ld_ready"}, ld_ready, 1);
    chk({tag, "_gray_ready"}, gray_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
    chk({tag, "_err_border"}, err_border, 0);
    chk({tag, "_err_dup"}, err_dup, 0);
    chk({tag, "_err_missing"}, err_missing, 0);
  endtask

  initial begin
    int beats;
    int cyc;
    int bad;

    vecs[0] = '{0, 14'd129,   8'h00, 8'h81, 15'd0, 1'b0};
    vecs[1] = '{0, 14'd16383, 8'h00, 8'hFF, 15'd0, 1'b0};
    vecs[2] = '{0, 14'd0,     8'h00, 8'h00, 15'd0, 1'b0};
    vecs[3] = '{0, 14'd300,   8'h00, 8'h2C, 15'd0, 1'b0};
    vecs[4] = '{1, 14'd0,     8'hA5, 8'h00, 15'd0, 1'b1};
    vecs[5] = '{1, 14'd127,   8'hA5, 8'h00, 15'd0, 1'b1};
    vecs[6] = '{1, 14'd16256, 8'hA5, 8'h00, 15'd0, 1'b1};
    vecs[7] = '{1, 14'd129,   8'h5A, 8'h00, 15'd1, 1'b1};
    vecs[8] = '{1, 14'd16383, 8'h33, 8'h00, 15'd1, 1'b1};
    vecs[9] = '{0, 14'd129,   8'h00, 8'h81, 15'd1, 1'b1};

    reset     = 1'b1;
    ld_valid  = 1'b0;
    ld_data   = '0;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = '0;
    finish    = 1'b0;
    rd_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    reset_checks("rst0");

    // LOAD ignores finish and result writes.
    finish    = 1'b1;
    lbp_valid = 1'b1;
    lbp_addr  = 14'd0;
    tick();
    finish    = 1'b0;
    lbp_valid = 1'b0;
    #1;
    chk("load_ignore_finish_ld_ready", ld_ready, 1);
    chk("load_ignore_lbp_err_border", err_border, 0);
    chk("load_gray_data_zero", gray_data, 0);

    load_image(64, "load1");

    gray_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        lbp_valid = 1'b1;
        lbp_addr  = vecs[i].addr;
        lbp_data  = vecs[i].data;
        tick();
        lbp_valid = 1'b0;
        #1;
      end else begin
        gray_addr = vecs[i].addr;
        #1;
        chk($sformatf("vec%0d_gray_data", i), gray_data, vecs[i].exp_gray);
        chk($sformatf("vec%0d_gray_ready", i), gray_ready, 1);
        tick();
      end
      chk($sformatf("vec%0d_wr_count", i), wr_count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_err_border", i), err_border, vecs[i].exp_border);
    end
    gray_req = 1'b0;

    // Every remaining interior pixel; finish rides with the final write.
    for (int a = 0; a < IMG_PIX; a++) begin
      if (!tb_border(a) && a != 129) begin
        lbp_valid = 1'b1;
        lbp_addr  = 14'(a);
        lbp_data  = 8'(a);
        finish    = (a == 16254);
        tick();
      end
    end
    lbp_valid = 1'b0;
    finish    = 1'b0;
    #1;
    chk("fill_wr_count", wr_count, INTERIOR_PIX);
    chk("drain_entry_rd_valid", rd_valid, 1);
    chk("drain_gray_ready", gray_ready, 0);
    chk("drain_err_border_sticky", err_border, 1);
    chk("drain_err_dup", err_dup, 0);
    chk("drain_err_missing", err_missing, 0);

    // Writes during DRAIN must not land or count.
    lbp_valid = 1'b1;
    lbp_addr  = 14'd130;
    lbp_data  = 8'hEE;
    beats = 0;
    cyc   = 0;
    bad   = 0;
    while (beats < IMG_PIX && cyc < 40000) begin
      rd_ready = (cyc % 2) == 1;
      #1;
      if (rd_valid !== 1'b1 || rd_data !== drain_exp(beats) ||
          rd_last !== (beats == IMG_PIX - 1)) begin
        bad++;
      end
      if (rd_ready && rd_valid) beats++;
      cyc++;
      tick();
    end
    rd_ready  = 1'b0;
    lbp_valid = 1'b0;
    #1;
    chk("drain_beats", beats, IMG_PIX);
    chk("drain_beat_errors", bad, 0);
    chk("done_flag", done, 1);
    chk("done_rd_valid", rd_valid, 0);
    chk("done_rd_last", rd_last, 0);
    chk("done_ld_ready", ld_ready, 0);
    chk("done_wr_count", wr_count, INTERIOR_PIX);
    tick();
    chk("done_held", done, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    reset_checks("rst1");

    load_image(0, "load2");
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'h11;
    tick();
    tick();
    lbp_valid = 1'b0;
    #1;
    chk("dup_wr_count", wr_count, 2);
    chk("dup_err_dup", err_dup, COVER);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    #1;
    chk("short_err_missing", err_missing, COVER);
    chk("short_rd_valid", rd_valid, 1);
    rd_ready = 1'b1;
    tick();
    tick();
    tick();
    rd_ready = 1'b0;
    #1;
    chk("mid_drain_rd_data_border", rd_data, 0);
    chk("mid_drain_rd_valid", rd_valid, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    reset_checks("rst_mid_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
